// File: rtl/trace_packetizer.sv
// trace_packetizer
// Buffers per-cycle retire records (pc, instr, alu, wb) in a small FIFO and
// serializes each one as a framed byte packet on a valid/ready byte stream.
// Packet: 0xA5, [seq], pc, instr, alu, wb. Each word is sent MSB byte first.
//
// Optional feature macro: TRACE_SEQ_EN
//   defined   -> an 8-bit sequence byte follows the header (18-byte packets).
//                The sequence counter advances on every retire, including
//                dropped ones.
//   undefined -> 17-byte packets, no sequence counter.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   retire_valid      record present this cycle
//   pc/instr/alu/wb   32-bit record fields
//   tx_ready          sink accepts tx_data this cycle
//   tx_data/tx_valid  registered byte stream output
//   ovf_clr           synchronous clear of overflow and drop_count
//   overflow          sticky drop flag
//   drop_count        saturating count of dropped records
//   fifo_level        records currently held in the FIFO
module trace_packetizer #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   retire_valid,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic [31:0]            alu,
  input  logic [31:0]            wb,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   ovf_clr,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef TRACE_SEQ_EN
  localparam int REC_W = 136;
`else
  localparam int REC_W = 128;
`endif
  localparam int PKT_W     = REC_W + 8;
  localparam int PKT_BYTES = PKT_W / 8;

  // state  | meaning
  // S_IDLE | no packet in flight; pops the FIFO head as soon as one exists
  // S_SEND | presenting packet bytes; reloads back-to-back after last byte
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           state, state_next;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop, drop, load, shift;
  logic [REC_W-1:0] rec_in, rec_head;
  logic [PKT_W-1:0] sh;
  logic [4:0]       byte_cnt;

`ifdef TRACE_SEQ_EN
  logic [7:0] seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               seq <= 8'd0;
    else if (retire_valid) seq <= seq + 8'd1;
  end

  assign rec_in = {seq, pc, instr, alu, wb};
`else
  assign rec_in = {pc, instr, alu, wb};
`endif

  // Full is judged on the level before this edge, so a push while full is
  // dropped even when the serializer pops in the same cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = retire_valid && !full;
  assign drop     = retire_valid && full;
  assign rec_head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_cnt == 5'd0) begin
            if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              shift      = 1'b1;
              state_next = S_IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift register holds the whole packet; its top byte is tx_data, so the
  // byte output is a flop and is held untouched while the sink stalls.
  // byte_cnt is a down-counter of bytes still to follow the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      byte_cnt <= 5'd0;
    end else if (load) begin
      sh       <= {8'hA5, rec_head};
      byte_cnt <= 5'(PKT_BYTES - 1);
    end else if (shift) begin
      sh <= {sh[PKT_W-9:0], 8'h00};
      if (byte_cnt != 5'd0) byte_cnt <= byte_cnt - 5'd1;
    end
  end

  assign tx_data  = sh[PKT_W-1 -: 8];
  assign tx_valid = (state == S_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_packetizer.sv
module tb_trace_packetizer;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
`ifdef TRACE_SEQ_EN
  localparam int SEQ_OFF = 1;
`else
  localparam int SEQ_OFF = 0;
`endif
  localparam int PKT = 17 + SEQ_OFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] pc = '0, instr = '0, alu = '0, wb = '0;
  logic        tx_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overflow;
  logic [DROP_W-1:0]      drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  trace_packetizer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid),
    .pc(pc), .instr(instr), .alu(alu), .wb(wb),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .ovf_clr(ovf_clr), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  sbq [$];
  int          captured = 0;
  int          started  = 0;
  int          accepted = 0;
  logic        ovf_m    = 1'b0;
  logic [15:0] drops_m  = '0;
  logic [7:0]  seq_m    = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    captured = 0;
    ovf_m    = 1'b0;
    drops_m  = '0;
    seq_m    = '0;
  endtask

  // One clock: drive inputs, let the edge happen, apply the packet rules.
  task automatic step(input logic rv, input logic [31:0] p, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] w,
                      input logic rdy, input logic clr);
    logic [31:0] words [4];
    retire_valid = rv; pc = p; instr = i; alu = a; wb = w;
    tx_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (retire_valid) begin
        if (captured - started < DEPTH) begin
          words[0] = pc; words[1] = instr; words[2] = alu; words[3] = wb;
          sbq.push_back(8'hA5);
          if (SEQ_OFF != 0) sbq.push_back(seq_m);
          for (int k = 0; k < 4; k++)
            for (int b = 3; b >= 0; b--) sbq.push_back(words[k][8*b +: 8]);
          captured++;
        end else begin
          ovf_m = 1'b1;
          if (drops_m != 16'hFFFF) drops_m++;
        end
        seq_m++;
      end
      if (ovf_clr) begin
        ovf_m   = 1'b0;
        drops_m = '0;
      end
    end
    #1;
  endtask

  task automatic rstep(input logic rv, input logic rdy, input logic clr);
    step(rv, $urandom, $urandom, $urandom, $urandom, rdy, clr);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && (sbq.size() != 0 || tx_valid); n++) rstep(0, 1, 0);
    chk("drain_done", sbq.size(), 0);
    chk("drain_idle", tx_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks the
  // status outputs against the model. A packet counts as popped once its
  // first byte is on the stream.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      accepted   = 0;
      started    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
      end
      started = accepted / PKT + ((((accepted % PKT) != 0) || tx_valid) ? 1 : 0);
      chk("fifo_level", fifo_level, captured - started);
      chk("overflow", overflow, ovf_m);
      chk("drop_count", drop_count, drops_m);
      if (tx_valid && tx_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
        end else begin
          chk("tx_byte", tx_data, sbq.pop_front());
        end
        accepted++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  logic [7:0] exp_single [17] = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00,
                                  8'h05, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h05};
  logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int run;
    logic [7:0] e;

    rstep(0, 0, 0);
    rstep(0, 0, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);
    rst = 1'b0;

    // single record, known bytes, one-cycle pop latency
    step(1, 32'h00400000, 32'h20080005, 32'h00000005, 32'h00000005, 1, 0);
    chk("lat_capture_valid", tx_valid, 0);
    chk("lat_capture_level", fifo_level, 1);
    rstep(0, 1, 0);
    chk("lat_pop_valid", tx_valid, 1);
    chk("lat_pop_level", fifo_level, 0);
    for (int i = 0; i < PKT; i++) begin
      if (SEQ_OFF != 0 && i == 1) e = 8'h00;
      else e = exp_single[(i > SEQ_OFF) ? i - SEQ_OFF : i];
      chk("single_byte", tx_data, e);
      chk("single_valid", tx_valid, 1);
      rstep(0, 1, 0);
    end
    chk("single_end_valid", tx_valid, 0);

    // backpressure 1,0,0,1
    rstep(1, 0, 0);
    rstep(1, 0, 0);
    for (int n = 0; n < 400 && (sbq.size() != 0 || tx_valid); n++) rstep(0, pat[n % 4], 0);
    chk("bp_done", sbq.size(), 0);

    // overflow: one record sits in the serializer, DEPTH fill the FIFO,
    // the remaining two are dropped
    do_reset();
    for (int n = 0; n < DEPTH + 3; n++) rstep(1, 0, 0);
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    rstep(0, 0, 1);
    chk("clr_flag", overflow, 0);
    chk("clr_drops", drop_count, 0);
    chk("clr_level", fifo_level, DEPTH);
    drain();

    // back-to-back: three records stream with no bubble
    rstep(1, 0, 0);
    rstep(1, 0, 0);
    rstep(1, 0, 0);
    run = 0;
    for (int n = 0; n < 200; n++) begin
      if (tx_valid) run++;
      else if (run > 0) break;
      rstep(0, 1, 0);
    end
    chk("b2b_run", run, 3 * PKT);

    // reset mid-packet
    rstep(1, 1, 0);
    rstep(1, 1, 0);
    for (int n = 0; n < 5; n++) rstep(0, 1, 0);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_level", fifo_level, 0);
    rstep(0, 1, 0);
    rstep(0, 1, 0);
    rst = 1'b0;
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_valid", tx_valid, 0);
    rstep(1, 1, 0);
    rstep(0, 1, 0);
    chk("post_rst_hdr", tx_data, 8'hA5);
    chk("post_rst_hv", tx_valid, 1);
    drain();

`ifdef TRACE_SEQ_EN
    // fill, then drop one record: its sequence number must leave a gap
    do_reset();
    for (int n = 0; n < DEPTH + 2; n++) rstep(1, 0, 0);
    chk("seq_drop", drop_count, 1);
    for (int n = 0; n < 60; n++) rstep(n % 20 == 0, 1, 0);
    drain();
`endif

    // randomized traffic at light and heavy retire rates
    for (int n = 0; n < 3000; n++)
      rstep(($urandom % 100) < ((n < 1500) ? 8 : 40), ($urandom % 100) < 75, ($urandom % 64) == 0);
    drain();
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
